alu_ctrl_decode: RTL
====================

Name: alu_ctrl_decode

Overview:
Pipelined decode stage that generates the ALU's control and operand-select signals from RV32I instructions. It drives the 4-bit ALU select encoding the ALU consumes, along with the immediate, register indices and writeback controls. It sits between fetch and execute. It holds one registered output slot with valid/ready handshakes on both sides and a flush input for branch redirect.

Parameters:
W_SIZE, 32, datapath width for instruction, PC and immediate.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  discard the held output and any same-cycle input
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept an instruction this cycle
in_inst  input  W_SIZE  instruction word
in_pc  input  W_SIZE  instruction PC
out_valid  output  1  decoded bundle valid
out_ready  input  1  execute accepts the bundle
alu_sel  output  4  ALU select
a_sel  output  1  ALU operand A source: 0 = rs1, 1 = pc
b_sel  output  1  ALU operand B source: 0 = rs2, 1 = imm
imm  output  W_SIZE  sign-extended immediate
rs1  output  5  source register 1 index
rs2  output  5  source register 2 index
rd  output  5  destination register index
reg_we  output  1  register writeback enable
wb_sel  output  2  writeback source: 00 = ALU, 01 = memory, 10 = pc+4
pc_out  output  W_SIZE  registered in_pc
illegal  output  1  unsupported opcode (only with the optional feature)

Behaviour:
- ALU select encoding:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - 1111 = pass B (LUI).
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer-in occurs when in_valid && in_ready; the decoded bundle is registered at that edge, so latency is 1 cycle.
  - Transfer-out occurs when out_valid && out_ready.
  - If only transfer-out occurs, out_valid goes to 0 next cycle.
  - Simultaneous transfer-in and transfer-out gives back-to-back throughput of 1 instruction/cycle.
  - While out_valid && !out_ready, all outputs hold stable.
- Flush: at the edge, out_valid goes to 0 and the same-cycle input is dropped. Flush has priority over load.
- Reset: out_valid=0 and every other output=0. Reset has priority over flush. Reset mid-stall discards the held bundle.
- Field extraction: rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7], f3=inst[14:12], f7b=inst[30].
- Decode by opcode inst[6:0]:
  - OP 0110011: alu_sel={f7b&(f3==000|f3==101), f3}; a=rs1, b=rs2; wb ALU; we=1.
  - OP-IMM 0010011: alu_sel={f7b&(f3==101), f3}; b=imm; I-imm; wb ALU; we=1. A set inst[30] on ADDI/ANDI etc. must NOT produce SUB.
  - LUI 0110111: alu_sel=1111; b=imm; U-imm; we=1.
  - AUIPC 0010111: ADD; a=pc; b=imm; U-imm; we=1.
  - JAL 1101111: ADD; a=pc; b=imm; J-imm; wb=10; we=1.
  - JALR 1100111: ADD; a=rs1; b=imm; I-imm; wb=10; we=1.
  - BRANCH 1100011: ADD; a=pc; b=imm; B-imm; we=0.
  - LOAD 0000011: ADD; a=rs1; b=imm; I-imm; wb=01; we=1.
  - STORE 0100011: ADD; a=rs1; b=imm; S-imm; we=0.
  - Anything else: NOP bundle (alu_sel=ADD, imm=0, we=0).
- Immediates:
  - All are sign-extended from inst[31].
  - U = {inst[31:12], 12'b0}.
  - B and J have bit 0 = 0.
- rd==0 forces reg_we=0.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: the illegal port exists; it is registered with the bundle and =1 for unlisted opcodes and for OP with inst[31:25] not in {0000000, 0100000} or inst[30]=1 with f3 not in {000, 101}. Illegal instructions still produce the NOP bundle.
- Undefined: illegal is tied to 0 and the checks are absent.

Test Plan:
- Reset → out_valid=0 and all outputs 0, in_ready=1.
- Issue 0x002081B3 (add x3,x1,x2), then 0x402081B3 (sub) back-to-back with out_ready=1 → alu_sel 0000 then 1000, rs1=1, rs2=2, rd=3, we=1, b_sel=0, one bundle per cycle.
- Issue 0xC0000093 (addi x1,x0,-1024) → alu_sel=0000, imm=0xFFFFFC00, b_sel=1. Issue 0x40335293 (srai x5,x6,3) → alu_sel=1101, imm=0x00000403.
- Issue 0x123452B7 (lui x5,0x12345) → alu_sel=1111, imm=0x12345000, we=1. Issue 0x00000013-type with rd=0 (addi x0,x0,5) → we=0.
- Backpressure: out_ready=0 for 3 cycles with the held bundle → in_ready=0 and outputs stable; release → the next instruction is accepted the same cycle.
- Flush while holding with in_valid=1 → next cycle out_valid=0, the input is not captured. With ILLEGAL_TRAP_EN, 0xFFFFFFFF → illegal=1, we=0.

Source files
------------

// File: rtl/alu_ctrl_decode.sv
// RV32I decode stage: turns one instruction into ALU select, operand select, immediate and writeback controls,
// held in a single registered slot with valid/ready on both sides. Optional macro ILLEGAL_TRAP_EN flags unsupported encodings.
module alu_ctrl_decode #(
  parameter int W_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_SIZE-1:0] in_inst,
  input  logic [W_SIZE-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_sel,
  output logic              a_sel,
  output logic              b_sel,
  output logic [W_SIZE-1:0] imm,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic              reg_we,
  output logic [1:0]        wb_sel,
  output logic [W_SIZE-1:0] pc_out,
  output logic              illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        f7b;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        load;
  logic        op_ok;

  logic [3:0]  d_alu;
  logic        d_a, d_b, d_we;
  logic [1:0]  d_wb;
  logic [31:0] d_imm;

  assign inst   = in_inst[31:0];
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7b    = inst[30];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;

`ifdef ILLEGAL_TRAP_EN
  logic d_ill;

  // Only the two defined funct7 values are legal, and the alternate form exists only for SUB/SRA.
  assign op_ok = ((inst[31:25] == 7'b0000000) || (inst[31:25] == 7'b0100000)) &&
                 (!inst[30] || (f3 == 3'b000) || (f3 == 3'b101));

  always_comb begin
    d_ill = 1'b0;
    case (opcode)
      OPC_OP:     d_ill = !op_ok;
      OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_BRANCH, OPC_LOAD, OPC_STORE: d_ill = 1'b0;
      default:    d_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)        illegal <= 1'b0;
    else if (load)  illegal <= d_ill;
  end
`else
  assign op_ok   = 1'b1;
  assign illegal = 1'b0;
`endif

  // Anything not decoded below falls through as a harmless NOP bundle.
  always_comb begin
    d_alu = ALU_ADD;
    d_a   = 1'b0;
    d_b   = 1'b0;
    d_imm = 32'b0;
    d_we  = 1'b0;
    d_wb  = 2'b00;
    case (opcode)
      OPC_OP: begin
        if (op_ok) begin
          d_alu = {f7b & ((f3 == 3'b000) || (f3 == 3'b101)), f3};
          d_we  = 1'b1;
        end
      end
      OPC_OPIMM: begin
        // inst[30] is immediate data here except for SRAI, so it must not turn ADDI into SUB.
        d_alu = {f7b & (f3 == 3'b101), f3};
        d_b   = 1'b1;
        d_imm = imm_i;
        d_we  = 1'b1;
      end
      OPC_LUI: begin
        d_alu = ALU_PASSB;
        d_b   = 1'b1;
        d_imm = imm_u;
        d_we  = 1'b1;
      end
      OPC_AUIPC: begin
        d_a   = 1'b1;
        d_b   = 1'b1;
        d_imm = imm_u;
        d_we  = 1'b1;
      end
      OPC_JAL: begin
        d_a   = 1'b1;
        d_b   = 1'b1;
        d_imm = imm_j;
        d_wb  = 2'b10;
        d_we  = 1'b1;
      end
      OPC_JALR: begin
        d_b   = 1'b1;
        d_imm = imm_i;
        d_wb  = 2'b10;
        d_we  = 1'b1;
      end
      OPC_BRANCH: begin
        d_a   = 1'b1;
        d_b   = 1'b1;
        d_imm = imm_b;
      end
      OPC_LOAD: begin
        d_b   = 1'b1;
        d_imm = imm_i;
        d_wb  = 2'b01;
        d_we  = 1'b1;
      end
      OPC_STORE: begin
        d_b   = 1'b1;
        d_imm = imm_s;
      end
      default: ;
    endcase
  end

  // Reset beats flush, flush beats load; a drained slot simply drops valid and keeps its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_sel   <= '0;
      a_sel     <= 1'b0;
      b_sel     <= 1'b0;
      imm       <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      reg_we    <= 1'b0;
      wb_sel    <= '0;
      pc_out    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      alu_sel   <= d_alu;
      a_sel     <= d_a;
      b_sel     <= d_b;
      imm       <= W_SIZE'($signed(d_imm));
      rs1       <= inst[19:15];
      rs2       <= inst[24:20];
      rd        <= inst[11:7];
      reg_we    <= d_we && (inst[11:7] != 5'd0);
      wb_sel    <= d_wb;
      pc_out    <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
